wta_spike_gen: RTL and testbench
================================

// Module: wta_spike_gen
// PURPOSE
//  Consumes the registered 3-input winner search (best potential + winner flags [3:1]).
//  Keeps one adaptive threshold per neuron.
//  Emits one winner spike event (id, potential) with a valid/ready handshake.
//  Winner's threshold rises on each accepted spike; all thresholds decay back toward their base value.
//  A refractory window follows each accepted spike. Feeds the event output / label stage of the ODESA layer.
// PARAMETERS
//  p_width        22  potential and threshold width (unsigned)
//  p_th_init      8   base (reset and decay-floor) threshold value
//  p_th_inc       4   threshold increment on accepted spike
//  p_decay_period 16  cycles between decay ticks (>=1)
//  p_refrac       8   refractory cycles after acceptance (0 = none)
// PORTS
//  i_clk        in   1          clock, rising edge
//  i_rst        in   1          asynchronous, active-high reset
//  i_valid      in   1          i_result/i_index valid this cycle
//  i_result     in   p_width    winning potential
//  i_index      in   3 [3:1]    winner flags; several set on tie; 0 = no winner
//  i_ready      in   1          downstream accepts spike
//  o_spike      out  1          spike valid
//  o_spike_id   out  2          winner id 1..3
//  o_spike_val  out  p_width    latched winning potential
//  o_threshold  out  3*p_width  {th3,th2,th1}, registered
//  o_busy       out  1          state != IDLE
//  o_drop       out  1          1-cycle pulse: sample discarded while busy
// BEHAVIOUR
//  Reset (async): state IDLE; o_spike/o_spike_id/o_spike_val/o_drop = 0; th1..3 = p_th_init; all counters 0.
//  Reset during HOLD discards the pending spike.
//  FSM IDLE -> HOLD -> REFRAC -> IDLE.
//   IDLE, on i_valid && i_index!=0:
//    - id = lowest set bit of i_index (priority 1>2>3).
//    - If i_result >= th[id] (unsigned, th value at the sampling edge): latch id/value, o_spike=1 after that edge, go HOLD.
//    - Else: stay IDLE, no side effects.
//   HOLD: o_spike, o_spike_id, o_spike_val held stable until i_ready=1.
//    - On the edge with o_spike && i_ready: o_spike<=0; th[id] <= min(th[id]+p_th_inc, 2^p_width-1).
//    - Next state: REFRAC if p_refrac>0, else IDLE.
//   REFRAC: exactly p_refrac cycles, then IDLE. New sample accepted on the first IDLE cycle.
//  Latency: sample edge N -> o_spike high in cycle N+1; min spike-to-spike period = 1 + ready wait + p_refrac + 1.
//  Drop: i_valid && i_index!=0 while HOLD or REFRAC -> o_drop=1 for the next cycle; sample ignored. No queueing.
//  Decay: free-running tick counter 0..p_decay_period-1, runs in every state.
//   On wrap, each th[k] > p_th_init decrements by 1; floor is p_th_init.
//   If increment and decay hit the same th on the same edge: increment applies, decay skipped for that neuron.
//  Increment arithmetic uses p_width+1 bits, then saturates; no wrap-around.
//  o_busy is combinational from state; all other outputs are registered.
// STRUCTURE
//  Shared include wta_pkg.vh:
//   - state localparams (IDLE=0, HOLD=1, REFRAC=2);
//   - 2-bit id encodings;
//   - counter widths via $clog2 of p_decay_period and p_refrac.
//  Sub-module adaptive_threshold (x3):
//   - th register, saturating increment, floored decay;
//   - inputs inc_en, decay_tick; output th.
//  Parent: FSM, priority select, compare, decay and refractory counters, handshake.
// TESTING
//  1 i_rst=1 mid-run -> o_spike=0, o_busy=0, o_threshold={8,8,8} immediately (async).
//  2 index=3'b001, result=10, i_ready=1 -> next cycle spike id=1 val=10.
//    Then th1=12, o_busy high 1+8 cycles, back to IDLE.
//  3 index=3'b010, result=7 (<8) -> no spike, thresholds unchanged, o_busy stays 0.
//  4 tie: index=3'b110, result=20 -> id=2, th2=12, th3 unchanged.
//  5 i_ready=0 for 5 cycles with extra valid samples ->
//    spike fields stable, o_drop pulse per extra sample, single th increment.
//  6 decay: th1=12, idle 64 cycles -> th1=8; 32 more cycles -> still 8.
//    Repeated spikes with p_width=5 -> th saturates at 31.

Source files
------------

// File: rtl/wta_spike_gen_pkg.sv
// Shared types and helpers for the winner-take-all spike generator:
// FSM state encoding, winner id encoding and counter sizing.
package wta_spike_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REFRAC = 2'd2
  } state_t;

  typedef logic [1:0] id_t;

  localparam id_t ID_NONE = 2'd0;
  localparam id_t ID_1    = 2'd1;
  localparam id_t ID_2    = 2'd2;
  localparam id_t ID_3    = 2'd3;

  // Ties resolve to the lowest-numbered neuron.
  function automatic id_t pick_winner(input logic [3:1] flags);
    if (flags[1])      return ID_1;
    else if (flags[2]) return ID_2;
    else if (flags[3]) return ID_3;
    else               return ID_NONE;
  endfunction

  // Bits needed for a down/up counter spanning 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wta_spike_gen_if.sv
// Sample-in / spike-out bundle of the spike generator. The master side
// feeds winner-search results and consumes spikes; the slave side is the generator.
interface wta_spike_gen_if #(
  parameter int p_width = 22
);
  logic                 i_valid;
  logic [p_width-1:0]   i_result;
  logic [3:1]           i_index;
  logic                 i_ready;
  logic                 o_spike;
  logic [1:0]           o_spike_id;
  logic [p_width-1:0]   o_spike_val;
  logic [3*p_width-1:0] o_threshold;
  logic                 o_busy;
  logic                 o_drop;

  modport master (
    output i_valid, i_result, i_index, i_ready,
    input  o_spike, o_spike_id, o_spike_val, o_threshold, o_busy, o_drop
  );

  modport slave (
    input  i_valid, i_result, i_index, i_ready,
    output o_spike, o_spike_id, o_spike_val, o_threshold, o_busy, o_drop
  );
endinterface

// File: rtl/wta_spike_gen_threshold.sv
// One neuron's adaptive threshold: saturating bump on an accepted spike,
// slow decay back down to the base value.
module adaptive_threshold #(
  parameter int p_width   = 22,
  parameter int p_th_init = 8,
  parameter int p_th_inc  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               inc_en,
  input  logic               decay_tick,
  output logic [p_width-1:0] th
);
  localparam logic [p_width-1:0] th_base = p_width'(p_th_init);

  // One extra bit so an overflowing increment is detected instead of wrapping.
  logic [p_width:0] th_sum;
  assign th_sum = {1'b0, th} + (p_width+1)'(p_th_inc);

  // NOTE: state updates use non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      th <= th_base;
    end else if (inc_en) begin
      th <= th_sum[p_width] ? '1 : th_sum[p_width-1:0];
    end else if (decay_tick && (th > th_base)) begin
      th <= th - p_width'(1);
    end
  end

endmodule

// File: rtl/wta_spike_gen.sv
// Turns registered 3-way winner results into handshaked spike events,
// with per-neuron adaptive thresholds and a refractory window after each spike.
module wta_spike_gen
  import wta_spike_gen_pkg::*;
#(
  parameter int p_width        = 22,
  parameter int p_th_init      = 8,
  parameter int p_th_inc       = 4,
  parameter int p_decay_period = 16,
  parameter int p_refrac       = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  wta_spike_gen_if.slave bus
);
  localparam int dcw = cnt_width(p_decay_period);
  localparam int rcw = cnt_width((p_refrac > 0) ? p_refrac : 1);
  localparam logic [dcw-1:0] decay_last  = dcw'(p_decay_period - 1);
  localparam logic [rcw-1:0] refrac_load = rcw'((p_refrac > 0) ? p_refrac - 1 : 0);

  state_t             state;
  id_t                spike_id;
  logic               spike;
  logic [p_width-1:0] spike_val;
  logic               drop;
  logic [dcw-1:0]     decay_cnt;
  logic [rcw-1:0]     refrac_cnt;

  logic [p_width-1:0] th [1:3];
  logic [3:1]         inc_en;
  logic               decay_tick;
  logic               sample_hit;
  logic               accept;
  id_t                sel_id;
  logic [p_width-1:0] sel_th;

  // NOTE: every signal driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sel_id = pick_winner(bus.i_index);
    sel_th = th[1];
    case (sel_id)
      ID_2:    sel_th = th[2];
      ID_3:    sel_th = th[3];
      default: sel_th = th[1];
    endcase
  end

  assign sample_hit = bus.i_valid && (bus.i_index != 3'b000);
  assign accept     = (state == ST_HOLD) && bus.i_ready;
  assign decay_tick = (decay_cnt == decay_last);

  for (genvar k = 1; k <= 3; k++) begin : g_th
    assign inc_en[k] = accept && (spike_id == id_t'(k));

    adaptive_threshold #(
      .p_width  (p_width),
      .p_th_init(p_th_init),
      .p_th_inc (p_th_inc)
    ) u_th (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .inc_en    (inc_en[k]),
      .decay_tick(decay_tick),
      .th        (th[k])
    );
  end

  // Free-running decay timebase, independent of the FSM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)           decay_cnt <= '0;
    else if (decay_tick) decay_cnt <= '0;
    else                 decay_cnt <= decay_cnt + dcw'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      spike      <= 1'b0;
      spike_id   <= ID_NONE;
      spike_val  <= '0;
      drop       <= 1'b0;
      refrac_cnt <= '0;
    end else begin
      drop <= sample_hit && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (sample_hit && (bus.i_result >= sel_th)) begin
            spike_id  <= sel_id;
            spike_val <= bus.i_result;
            spike     <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.i_ready) begin
            spike <= 1'b0;
            if (p_refrac > 0) begin
              state      <= ST_REFRAC;
              refrac_cnt <= refrac_load;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_REFRAC: begin
          if (refrac_cnt == '0) state <= ST_IDLE;
          else                  refrac_cnt <= refrac_cnt - rcw'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_spike     = spike;
  assign bus.o_spike_id  = spike_id;
  assign bus.o_spike_val = spike_val;
  assign bus.o_drop      = drop;
  assign bus.o_busy      = (state != ST_IDLE);
  assign bus.o_threshold = {th[3], th[2], th[1]};

endmodule

// File: tb/tb_wta_spike_gen.sv
// Directed bench for wta_spike_gen: single-sample vector table plus
// hand-written stall, reset, decay and saturation sequences.
module tb_wta_spike_gen;

  localparam int W   = 22;
  localparam int REF = 8;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  wta_spike_gen_if #(.p_width(W)) bus ();
  wta_spike_gen_if #(.p_width(5)) sat_bus ();

  wta_spike_gen #(
    .p_width(W), .p_th_init(8), .p_th_inc(4), .p_decay_period(16), .p_refrac(REF)
  ) u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
  );

  wta_spike_gen #(
    .p_width(5), .p_th_init(8), .p_th_inc(4), .p_decay_period(1024), .p_refrac(0)
  ) u_sat (
    .i_clk(i_clk), .i_rst(i_rst), .bus(sat_bus)
  );

  typedef struct {
    logic [2:0]   index;
    logic [W-1:0] result;
    logic         exp_spike;
    logic [1:0]   exp_id;
    logic [65:0]  exp_th;
  } vec_t;

  vec_t vecs [7];
  int   checks = 0;
  int   errors = 0;
  int   edges  = 0;

  function automatic logic [65:0] mk_th(input int t1, input int t2, input int t3);
    return {W'(t3), W'(t2), W'(t1)};
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    edges++;
    @(negedge i_clk);
  endtask

  task automatic step_to(input int n);
    while (edges < n) step();
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0; bus.i_index = 3'b000; bus.i_result = '0; bus.i_ready = 1'b1;
    sat_bus.i_valid = 1'b0; sat_bus.i_index = 3'b000; sat_bus.i_result = '0; sat_bus.i_ready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b1;
    #2;
    i_rst = 1'b0;
    edges = 0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int busy_cnt;
    int guard;
    string tag;
    tag = $sformatf("vec%0d", n);
    bus.i_ready  = 1'b1;
    bus.i_valid  = 1'b1;
    bus.i_index  = v.index;
    bus.i_result = v.result;
    step();
    bus.i_valid = 1'b0;
    check({tag, " spike"}, 66'(bus.o_spike), 66'(v.exp_spike));
    if (v.exp_spike) begin
      check({tag, " id"}, 66'(bus.o_spike_id), 66'(v.exp_id));
      check({tag, " val"}, 66'(bus.o_spike_val), 66'(v.result));
      busy_cnt = 0;
      guard    = 0;
      while (bus.o_busy && guard < 30) begin
        busy_cnt++;
        guard++;
        step();
      end
      check({tag, " busy_cycles"}, 66'(busy_cnt), 66'(1 + REF));
    end else begin
      check({tag, " busy"}, 66'(bus.o_busy), 66'(0));
      step();
      check({tag, " busy_after"}, 66'(bus.o_busy), 66'(0));
    end
    check({tag, " spike_end"}, 66'(bus.o_spike), 66'(0));
    check({tag, " threshold"}, 66'(bus.o_threshold), v.exp_th);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic prev_extra;
    logic extra;
    int   guard;
    int   exp1;

    vecs[0] = '{3'b001, W'(10),         1'b1, 2'd1, mk_th(12, 8, 8)};
    vecs[1] = '{3'b010, W'(7),          1'b0, 2'd0, mk_th(8, 8, 8)};
    vecs[2] = '{3'b110, W'(20),         1'b1, 2'd2, mk_th(8, 12, 8)};
    vecs[3] = '{3'b100, W'(8),          1'b1, 2'd3, mk_th(8, 8, 12)};
    vecs[4] = '{3'b011, W'(7),          1'b0, 2'd0, mk_th(8, 8, 8)};
    vecs[5] = '{3'b000, W'(100),        1'b0, 2'd0, mk_th(8, 8, 8)};
    vecs[6] = '{3'b111, W'(22'h3fffff), 1'b1, 2'd1, mk_th(12, 8, 8)};

    do_reset();
    step();
    check("reset spike", 66'(bus.o_spike), 66'(0));
    check("reset busy", 66'(bus.o_busy), 66'(0));
    check("reset drop", 66'(bus.o_drop), 66'(0));
    check("reset th", 66'(bus.o_threshold), mk_th(8, 8, 8));

    foreach (vecs[i]) begin
      do_reset();
      run_vec(vecs[i], i);
    end

    // Asynchronous reset while a spike is pending in HOLD.
    do_reset();
    run_vec('{3'b010, W'(20), 1'b1, 2'd2, mk_th(8, 12, 8)}, 100);
    bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_index = 3'b001; bus.i_result = W'(30);
    step();
    bus.i_valid = 1'b0;
    check("pre_rst spike", 66'(bus.o_spike), 66'(1));
    #2 i_rst = 1'b1;
    #1;
    check("async_rst spike", 66'(bus.o_spike), 66'(0));
    check("async_rst busy", 66'(bus.o_busy), 66'(0));
    check("async_rst th", 66'(bus.o_threshold), mk_th(8, 8, 8));
    check("async_rst val", 66'(bus.o_spike_val), 66'(0));
    #1 i_rst = 1'b0;
    edges = 0;
    bus.i_ready = 1'b1;
    step();
    step();
    check("post_rst spike", 66'(bus.o_spike), 66'(0));
    check("post_rst busy", 66'(bus.o_busy), 66'(0));

    // Downstream stall with extra samples arriving during HOLD and REFRAC.
    do_reset();
    bus.i_ready = 1'b0; bus.i_valid = 1'b1; bus.i_index = 3'b001; bus.i_result = W'(10);
    step();
    prev_extra = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall%0d spike", i), 66'(bus.o_spike), 66'(1));
      check($sformatf("stall%0d id", i), 66'(bus.o_spike_id), 66'(1));
      check($sformatf("stall%0d val", i), 66'(bus.o_spike_val), 66'(10));
      check($sformatf("stall%0d drop", i), 66'(bus.o_drop), 66'(prev_extra));
      extra = (i % 2 == 0);
      bus.i_valid = extra; bus.i_index = 3'b010; bus.i_result = W'(50);
      prev_extra = extra;
      step();
    end
    check("stall_end drop", 66'(bus.o_drop), 66'(prev_extra));
    check("stall_end spike", 66'(bus.o_spike), 66'(1));
    bus.i_ready = 1'b1; bus.i_valid = 1'b0;
    step();
    check("accept spike", 66'(bus.o_spike), 66'(0));
    check("accept th", 66'(bus.o_threshold), mk_th(12, 8, 8));
    check("accept busy", 66'(bus.o_busy), 66'(1));
    bus.i_valid = 1'b1; bus.i_index = 3'b001; bus.i_result = W'(50);
    step();
    bus.i_valid = 1'b0;
    check("refrac drop", 66'(bus.o_drop), 66'(1));
    check("refrac spike", 66'(bus.o_spike), 66'(0));
    step();
    check("refrac drop_clear", 66'(bus.o_drop), 66'(0));
    guard = 0;
    while (bus.o_busy && guard < 30) begin
      guard++;
      step();
    end
    check("stall idle_edge", 66'(edges), 66'(15));
    check("stall single_inc", 66'(bus.o_threshold), mk_th(12, 8, 8));
    check("stall no_respike", 66'(bus.o_spike), 66'(0));

    // Increment coinciding with a decay tick, then decay down to the floor.
    do_reset();
    step_to(14);
    bus.i_ready = 1'b1; bus.i_valid = 1'b1; bus.i_index = 3'b001; bus.i_result = W'(10);
    step();
    bus.i_valid = 1'b0;
    check("decay spike", 66'(bus.o_spike), 66'(1));
    step();
    check("inc_over_decay th", 66'(bus.o_threshold), mk_th(12, 8, 8));
    step_to(31);
    check("decay e31", 66'(bus.o_threshold), mk_th(12, 8, 8));
    step_to(32);
    check("decay e32", 66'(bus.o_threshold), mk_th(11, 8, 8));
    step_to(48);
    check("decay e48", 66'(bus.o_threshold), mk_th(10, 8, 8));
    step_to(80);
    check("decay floor", 66'(bus.o_threshold), mk_th(8, 8, 8));
    step_to(112);
    check("decay hold_floor", 66'(bus.o_threshold), mk_th(8, 8, 8));

    // Saturation on a 5-bit instance with no refractory window.
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      sat_bus.i_valid = 1'b1; sat_bus.i_index = 3'b001; sat_bus.i_result = 5'd31;
      step();
      sat_bus.i_valid = 1'b0;
      check($sformatf("sat%0d spike", k), 66'(sat_bus.o_spike), 66'(1));
      step();
      exp1 = (8 + 4 * k > 31) ? 31 : 8 + 4 * k;
      check($sformatf("sat%0d busy", k), 66'(sat_bus.o_busy), 66'(0));
      check($sformatf("sat%0d th", k), 66'(sat_bus.o_threshold),
            66'((8 << 10) | (8 << 5) | exp1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
